// File: rtl/sb_tx_framer_if.sv
// ---------------------------------------------------------------------------
// sb_tx_framer_if
// Byte stream from the sideband transaction generator into the sideband
// transmit framer.
//   tx_data  [7:0]  payload byte
//   tx_valid        tx_data is valid
//   tx_sop          byte is the first of a transaction
//   tx_eop          byte is the last of a transaction
//   tx_ready        framer holding register is empty; a byte is taken on
//                   tx_valid & tx_ready at the clock edge
// Modports: master = transaction generator, slave = framer.
// ---------------------------------------------------------------------------
interface sb_tx_framer_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_sop;
   logic       tx_eop;
   logic       tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      output tx_sop,
      output tx_eop,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      input  tx_sop,
      input  tx_eop,
      output tx_ready
   );
endinterface

// File: rtl/sb_tx_framer.sv
// ---------------------------------------------------------------------------
// sb_tx_framer
// Sideband transmit path: frames transaction bytes as
//   DLE, payload (each DLE byte doubled), DLE, ETX
// and serializes every symbol as start(0), 8 data bits LSB first, stop(1)
// onto sbtx.
//
// Ports:
//   SB_clock   block clock
//   rst_n      asynchronous active-low reset
//   sb_enable  1 = link up; 0 = sbtx held low, all state flushed
//   tx         sb_tx_framer_if.slave byte stream (data/valid/sop/eop/ready)
//   sbtx       serial sideband output
//   tx_busy    transaction in flight (leading DLE start bit .. ETX stop bit)
//   frame_err  one-cycle pulse on a protocol violation or an aborted frame
//
// Optional feature (macro SB_TX_GAP_EN): when defined, MIN_GAP idle-high bit
// periods are inserted after every ETX before the next transaction starts.
// ---------------------------------------------------------------------------
module sb_tx_framer #(
   parameter int unsigned CLKS_PER_BIT = 32'd1,
   parameter logic [7:0]  DLE          = 8'hFE,
   parameter logic [7:0]  ETX          = 8'h40,
   parameter int unsigned MIN_GAP      = 32'd10
) (
   input  logic           SB_clock,
   input  logic           rst_n,
   input  logic           sb_enable,
   sb_tx_framer_if.slave  tx,
   output logic           sbtx,
   output logic           tx_busy,
   output logic           frame_err
);

   localparam int unsigned BW = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 32'd1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 32'd1);
   localparam logic [15:0]   GAP_LAST  = 16'(MIN_GAP * CLKS_PER_BIT - 32'd1);
`ifdef SB_TX_GAP_EN
   localparam logic GAP_EN = 1'b1;
`else
   localparam logic GAP_EN = 1'b0;
`endif

   // State names the symbol currently on the wire (or about to be, when stalled).
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START_DLE = 3'd1,
      S_PAYLOAD   = 3'd2,
      S_STUFF     = 3'd3,
      S_END_DLE   = 3'd4,
      S_END_ETX   = 3'd5,
      S_GAP       = 3'd6
   } state_t;

   state_t          state_r;
   state_t          state_s;

   logic            hold_valid_r;
   logic [7:0]      hold_data_r;
   logic            hold_sop_r;
   logic            hold_eop_r;
   logic            tx_ready_r;
   logic            tx_busy_r;
   logic            frame_err_r;

   logic            sbtx_r;
   logic [8:0]      shift_r;
   logic [3:0]      bit_cnt_r;
   logic [BW-1:0]   baud_cnt_r;
   logic            ser_busy_r;

   logic            pay_dle_r;
   logic            pay_eop_r;
   logic [15:0]     gap_cnt_r;

   logic            accept_s;
   logic            ser_free_s;
   logic            load_s;
   logic [7:0]      load_byte_s;
   logic [9:0]      load_sym_s;
   logic            consume_s;
   logic            set_pay_s;
   logic            proto_err_s;
   logic            gap_start_s;

   // Wire format of one symbol: stop bit, data, start bit (bit 0 sent first).
   function automatic logic [9:0] make_symbol(input logic [7:0] b);
      return {1'b1, b, 1'b0};
   endfunction

   assign accept_s   = tx.tx_valid & tx_ready_r;
   // Free when idle, or in the last cycle of a stop bit so symbols abut.
   assign ser_free_s = ~ser_busy_r | ((bit_cnt_r == 4'd9) & (baud_cnt_r == BAUD_LAST));
   assign load_sym_s = make_symbol(load_byte_s);

   assign tx.tx_ready = tx_ready_r;
   assign sbtx        = sbtx_r;
   assign tx_busy     = tx_busy_r;
   assign frame_err   = frame_err_r;

   // Byte scheduler: next state and which symbol to hand to the serializer.
   always_comb begin
      state_s     = state_r;
      load_s      = 1'b0;
      load_byte_s = 8'h00;
      consume_s   = 1'b0;
      set_pay_s   = 1'b0;
      proto_err_s = 1'b0;
      gap_start_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (hold_valid_r && ser_free_s) begin
               if (hold_sop_r) begin
                  // sop byte stays held; it follows the leading DLE
                  state_s     = S_START_DLE;
                  load_s      = 1'b1;
                  load_byte_s = DLE;
               end else begin
                  consume_s   = 1'b1;
                  proto_err_s = 1'b1;
               end
            end else begin
               state_s = S_IDLE;
            end
         end
         S_START_DLE, S_PAYLOAD, S_STUFF: begin
            if (!ser_free_s) begin
               state_s = state_r;
            end else if ((state_r == S_PAYLOAD) && pay_dle_r) begin
               state_s     = S_STUFF;
               load_s      = 1'b1;
               load_byte_s = DLE;
            end else if ((state_r != S_START_DLE) && pay_eop_r) begin
               state_s     = S_END_DLE;
               load_s      = 1'b1;
               load_byte_s = DLE;
            end else if (hold_valid_r) begin
               state_s     = S_PAYLOAD;
               load_s      = 1'b1;
               load_byte_s = hold_data_r;
               consume_s   = 1'b1;
               set_pay_s   = 1'b1;
               // Only the byte right after the leading DLE may carry sop.
               proto_err_s = hold_sop_r & (state_r != S_START_DLE);
            end else begin
               state_s = state_r;
            end
         end
         S_END_DLE: begin
            if (ser_free_s) begin
               state_s     = S_END_ETX;
               load_s      = 1'b1;
               load_byte_s = ETX;
            end else begin
               state_s = S_END_DLE;
            end
         end
         S_END_ETX: begin
            if (!ser_free_s) begin
               state_s = S_END_ETX;
            end else if (GAP_EN) begin
               state_s     = S_GAP;
               gap_start_s = 1'b1;
            end else if (hold_valid_r && hold_sop_r) begin
               state_s     = S_START_DLE;
               load_s      = 1'b1;
               load_byte_s = DLE;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_GAP: begin
            if (gap_cnt_r != GAP_LAST) begin
               state_s = S_GAP;
            end else if (hold_valid_r && hold_sop_r) begin
               // load in the last gap cycle so the start bit follows the gap directly
               state_s     = S_START_DLE;
               load_s      = 1'b1;
               load_byte_s = DLE;
            end else begin
               state_s = S_IDLE;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   // Scheduler state, busy flag and error pulse.
   always_ff @(posedge SB_clock or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         tx_busy_r   <= 1'b0;
         frame_err_r <= 1'b0;
      end else if (!sb_enable) begin
         state_r     <= S_IDLE;
         tx_busy_r   <= 1'b0;
         frame_err_r <= tx_busy_r;
      end else begin
         state_r     <= state_s;
         tx_busy_r   <= (state_s != S_IDLE) && (state_s != S_GAP);
         frame_err_r <= proto_err_s;
      end
   end

   // Holding register and registered ready (one bubble after consumption).
   always_ff @(posedge SB_clock or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid_r <= 1'b0;
         hold_data_r  <= 8'h00;
         hold_sop_r   <= 1'b0;
         hold_eop_r   <= 1'b0;
         tx_ready_r   <= 1'b0;
      end else if (!sb_enable) begin
         hold_valid_r <= 1'b0;
         hold_data_r  <= 8'h00;
         hold_sop_r   <= 1'b0;
         hold_eop_r   <= 1'b0;
         tx_ready_r   <= 1'b0;
      end else begin
         if (accept_s) begin
            hold_valid_r <= 1'b1;
            hold_data_r  <= tx.tx_data;
            hold_sop_r   <= tx.tx_sop;
            hold_eop_r   <= tx.tx_eop;
         end else if (consume_s) begin
            hold_valid_r <= 1'b0;
         end else begin
            hold_valid_r <= hold_valid_r;
         end
         tx_ready_r <= ~hold_valid_r & ~accept_s;
      end
   end

   // Attributes of the payload byte last sent, plus the inter-frame gap counter.
   always_ff @(posedge SB_clock or negedge rst_n) begin
      if (!rst_n) begin
         pay_dle_r <= 1'b0;
         pay_eop_r <= 1'b0;
         gap_cnt_r <= 16'd0;
      end else if (!sb_enable) begin
         pay_dle_r <= 1'b0;
         pay_eop_r <= 1'b0;
         gap_cnt_r <= 16'd0;
      end else begin
         if (set_pay_s) begin
            pay_dle_r <= (hold_data_r == DLE);
            pay_eop_r <= hold_eop_r;
         end
         if (gap_start_s) begin
            gap_cnt_r <= 16'd0;
         end else if (state_r == S_GAP) begin
            gap_cnt_r <= gap_cnt_r + 16'd1;
         end
      end
   end

   // Serializer: sbtx is registered, so a symbol loaded in cycle N starts in N+1.
   always_ff @(posedge SB_clock or negedge rst_n) begin
      if (!rst_n) begin
         sbtx_r     <= 1'b0;
         shift_r    <= 9'd0;
         bit_cnt_r  <= 4'd0;
         baud_cnt_r <= '0;
         ser_busy_r <= 1'b0;
      end else if (!sb_enable) begin
         sbtx_r     <= 1'b0;
         shift_r    <= 9'd0;
         bit_cnt_r  <= 4'd0;
         baud_cnt_r <= '0;
         ser_busy_r <= 1'b0;
      end else if (load_s) begin
         sbtx_r     <= load_sym_s[0];
         shift_r    <= load_sym_s[9:1];
         bit_cnt_r  <= 4'd0;
         baud_cnt_r <= '0;
         ser_busy_r <= 1'b1;
      end else if (ser_busy_r) begin
         if (baud_cnt_r == BAUD_LAST) begin
            baud_cnt_r <= '0;
            if (bit_cnt_r == 4'd9) begin
               ser_busy_r <= 1'b0;
               sbtx_r     <= 1'b1;
            end else begin
               bit_cnt_r <= bit_cnt_r + 4'd1;
               sbtx_r    <= shift_r[0];
               shift_r   <= {1'b0, shift_r[8:1]};
            end
         end else begin
            baud_cnt_r <= baud_cnt_r + BW'(1);
         end
      end else begin
         sbtx_r <= 1'b1;
      end
   end

endmodule
